// File: rtl/nco_pkg.sv
// Shared widths, types and quarter-wave table generator for the dds_nco slice.
package nco_pkg;

  localparam int W_DDS         = 32;
  localparam int W_LUT         = 10;
  localparam int W_OUT         = 12;
  localparam int STABLE_CYCLES = 1024;

  localparam real C_PI = 3.14159265358979323846;

  typedef enum logic [1:0] {Q0 = 2'd0, Q1 = 2'd1, Q2 = 2'd2, Q3 = 2'd3} quadrant_t;
  typedef logic [W_LUT-1:0]        lut_addr_t;
  typedef logic signed [W_OUT-1:0] sample_t;

  // Half-step offset keeps every entry strictly positive and symmetric across the quarter.
  function automatic int lut_value(input int addr, input int w_lut, input int w_out);
    real amp;
    real ang;
    amp = real'((1 << (w_out - 1)) - 1);
    ang = 2.0 * C_PI * (real'(addr) + 0.5) / real'(1 << (w_lut + 2));
    return $rtoi(amp * $sin(ang) + 0.5);
  endfunction

endpackage

// File: rtl/nco_quarter_rom.sv
// Dual-read-port quarter-wave sine ROM, one cycle read latency, contents built at elaboration.
module nco_quarter_rom
  import nco_pkg::*;
#(
  parameter int width_lut = W_LUT,
  parameter int width_out = W_OUT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_en,
  input  logic [width_lut-1:0] i_addr_a,
  input  logic [width_lut-1:0] i_addr_b,
  output logic [width_out-1:0] o_data_a,
  output logic [width_out-1:0] o_data_b
);

  logic [width_out-1:0] w_table [0:(1 << width_lut)-1];

  for (genvar g = 0; g < (1 << width_lut); g++) begin : g_tab
    localparam int C_V = lut_value(g, width_lut, width_out);
    assign w_table[g] = width_out'(C_V);
  end

  // Registered read of both ports; held while the pipeline is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_data_a <= '0;
      o_data_b <= '0;
    end else if (i_en) begin
      o_data_a <= w_table[i_addr_a];
      o_data_b <= w_table[i_addr_b];
    end
  end

endmodule

// File: rtl/dds_nco.sv
// Quadrature NCO: debounced increment, phase-continuous accumulator, folded quarter-wave ROM.
// Optional pre-truncation phase dither is enabled by defining NCO_DITHER_EN.
module dds_nco
  import nco_pkg::*;
#(
  parameter int width_dds     = W_DDS,
  parameter int width_lut     = W_LUT,
  parameter int width_out     = W_OUT,
  parameter int stable_cycles = STABLE_CYCLES
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [width_dds-1:0]        K,
  input  logic                        en,
  output logic signed [width_out-1:0] lo_i,
  output logic signed [width_out-1:0] lo_q,
  output logic                        valid,
  output logic                        tune_done
);

  localparam int C_CW = $clog2(stable_cycles);
  localparam logic [C_CW-1:0] C_CNT_MAX = C_CW'(stable_cycles - 1);

  logic [width_dds-1:0]        r_k_smp;
  logic [width_dds-1:0]        r_k_act;
  logic [width_dds-1:0]        r_phase;
  logic [C_CW-1:0]             r_stab_cnt;
  logic [C_CW-1:0]             w_cnt_next;
  logic                        w_fire;
  logic [width_lut+1:0]        w_sel;
  quadrant_t                   r_q1;
  quadrant_t                   r_q2;
  logic [width_lut-1:0]        r_a1;
  logic signed [width_out-1:0] w_rom_a;
  logic signed [width_out-1:0] w_rom_na;
  logic signed [width_out-1:0] w_sin;
  logic signed [width_out-1:0] w_cos;
  logic [1:0]                  r_vpipe;

  // The fire test uses the count this edge will store, so K held from edge n loads at n+stable_cycles.
  always_comb begin
    w_cnt_next = r_stab_cnt;
    if (K != r_k_smp) begin
      w_cnt_next = '0;
    end else if (r_stab_cnt != C_CNT_MAX) begin
      w_cnt_next = r_stab_cnt + C_CW'(1);
    end else begin
      w_cnt_next = r_stab_cnt;
    end
    w_fire = (w_cnt_next == C_CNT_MAX) && (r_k_smp != r_k_act);
  end

  // K qualifier runs regardless of en.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_k_smp    <= '0;
      r_k_act    <= '0;
      r_stab_cnt <= '0;
      tune_done  <= 1'b0;
    end else begin
      r_k_smp    <= K;
      r_stab_cnt <= w_cnt_next;
      tune_done  <= w_fire;
      if (w_fire) begin
        r_k_act <= r_k_smp;
      end
    end
  end

`ifdef NCO_DITHER_EN
  localparam int C_TRUNC = width_dds - 2 - width_lut;
  localparam logic [width_dds-1:0] C_DMASK = (width_dds'(1) << C_TRUNC) - width_dds'(1);

  logic [16:0] r_lfsr;

  // x^17 + x^14 + 1 dither source, stepped with the pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr <= 17'd1;
    end else if (en) begin
      r_lfsr <= {r_lfsr[15:0], r_lfsr[16] ^ r_lfsr[13]};
    end
  end

  assign w_sel = (width_lut + 2)'((r_phase + (width_dds'(r_lfsr) & C_DMASK)) >> C_TRUNC);
`else
  assign w_sel = r_phase[width_dds-1 -: width_lut+2];
`endif

  // S0 accumulator and S1 quadrant/address split; never cleared on retune.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase <= '0;
      r_q1    <= Q0;
      r_a1    <= '0;
      r_q2    <= Q0;
      r_vpipe <= 2'b00;
    end else if (en) begin
      r_phase <= r_phase + r_k_act;
      r_q1    <= quadrant_t'(w_sel[width_lut+1 -: 2]);
      r_a1    <= w_sel[width_lut-1:0];
      r_q2    <= r_q1;
      r_vpipe <= {r_vpipe[0], 1'b1};
    end
  end

  nco_quarter_rom #(
    .width_lut (width_lut),
    .width_out (width_out)
  ) u_rom (
    .clk      (clk),
    .reset    (reset),
    .i_en     (en),
    .i_addr_a (r_a1),
    .i_addr_b (~r_a1),
    .o_data_a (w_rom_a),
    .o_data_b (w_rom_na)
  );

  // Quadrant folding of the two ROM reads into sine and cosine.
  always_comb begin
    w_sin = '0;
    w_cos = '0;
    case (r_q2)
      Q0: begin w_sin = w_rom_a;   w_cos = w_rom_na;  end
      Q1: begin w_sin = w_rom_na;  w_cos = -w_rom_a;  end
      Q2: begin w_sin = -w_rom_a;  w_cos = -w_rom_na; end
      Q3: begin w_sin = -w_rom_na; w_cos = w_rom_a;   end
      default: begin w_sin = '0;   w_cos = '0;        end
    endcase
  end

  // S3 output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lo_i  <= '0;
      lo_q  <= '0;
      valid <= 1'b0;
    end else if (en) begin
      lo_i  <= w_cos;
      lo_q  <= w_sin;
      valid <= r_vpipe[1];
    end
  end

endmodule

// File: tb/tb_dds_nco.sv
// Directed bench for dds_nco: reset, glitch rejection, quarter-rate tone, stall, retune, async reset.
module tb_dds_nco;

  logic               clk = 1'b0;
  logic               reset;
  logic               en;
  logic [31:0]        K;
  logic signed [11:0] lo_i;
  logic signed [11:0] lo_q;
  logic               valid;
  logic               tune_done;

  int total = 0;
  int bad   = 0;

  logic signed [11:0] exp_i [4];
  logic signed [11:0] exp_q [4];
  int last_idx;

  localparam logic [31:0] K_QTR = 32'h4000_0000;
  localparam logic [31:0] K_877 = 32'h5D8E_38E3;

  dds_nco dut (
    .clk       (clk),
    .reset     (reset),
    .K         (K),
    .en        (en),
    .lo_i      (lo_i),
    .lo_q      (lo_q),
    .valid     (valid),
    .tune_done (tune_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; K = 32'd0;
    step(); step();
    total++; if (lo_i !== 12'sd0) begin bad++; $display("FAIL rst_lo_i: got %0d want 0", lo_i); end
    total++; if (lo_q !== 12'sd0) begin bad++; $display("FAIL rst_lo_q: got %0d want 0", lo_q); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", valid); end
    total++; if (tune_done !== 1'b0) begin bad++; $display("FAIL rst_tune: got %b want 0", tune_done); end
    reset = 1'b0; en = 1'b1;
    for (int i = 1; i <= 1030; i++) begin
      step();
      total++;
      if (valid !== (i >= 3)) begin bad++; $display("FAIL k0_valid: cyc %0d got %b want %b", i, valid, (i >= 3)); end
      total++;
      if (tune_done !== 1'b0) begin bad++; $display("FAIL k0_tune: cyc %0d got %b want 0", i, tune_done); end
      if (i >= 3) begin
        total++;
        if (lo_i !== 12'sd2047 || lo_q !== 12'sd2) begin
          bad++; $display("FAIL k0_out: cyc %0d got (%0d,%0d) want (2047,2)", i, lo_i, lo_q);
        end
      end
    end
  endtask

  task automatic test_glitch();
    K = 32'h5555_5555;
    for (int i = 1; i <= 1600; i++) begin
      if (i == 501) K = 32'd0;
      step();
      total++;
      if (tune_done !== 1'b0) begin bad++; $display("FAIL glitch_tune: cyc %0d got %b want 0", i, tune_done); end
      total++;
      if (lo_i !== 12'sd2047 || lo_q !== 12'sd2) begin
        bad++; $display("FAIL glitch_out: cyc %0d got (%0d,%0d) want (2047,2)", i, lo_i, lo_q);
      end
    end
    total++;
    if (dut.r_k_act !== 32'd0) begin bad++; $display("FAIL glitch_kact: got %h want 0", dut.r_k_act); end
  endtask

  task automatic test_quarter();
    int idx;
    K = K_QTR;
    for (int i = 1; i <= 1024; i++) begin
      step();
      total++;
      if (tune_done !== (i == 1024)) begin
        bad++; $display("FAIL qtr_tune: cyc %0d got %b want %b", i, tune_done, (i == 1024));
      end
    end
    for (int j = 1; j <= 12; j++) begin
      step();
      idx = (j >= 3) ? ((j - 3) % 4) : 0;
      total++;
      if (lo_i !== exp_i[idx] || lo_q !== exp_q[idx]) begin
        bad++; $display("FAIL qtr_seq: step %0d got (%0d,%0d) want (%0d,%0d)", j, lo_i, lo_q, exp_i[idx], exp_q[idx]);
      end
      total++;
      if (tune_done !== 1'b0) begin bad++; $display("FAIL qtr_tune_once: step %0d got %b want 0", j, tune_done); end
      last_idx = idx;
    end
  endtask

  task automatic test_en_hold();
    int idx;
    en = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      total++;
      if (lo_i !== exp_i[last_idx] || lo_q !== exp_q[last_idx] || valid !== 1'b1) begin
        bad++; $display("FAIL hold: cyc %0d got (%0d,%0d,v%b) want (%0d,%0d,v1)", i, lo_i, lo_q, valid, exp_i[last_idx], exp_q[last_idx]);
      end
    end
    en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      idx = (last_idx + i) % 4;
      total++;
      if (lo_i !== exp_i[idx] || lo_q !== exp_q[idx]) begin
        bad++; $display("FAIL resume: cyc %0d got (%0d,%0d) want (%0d,%0d)", i, lo_i, lo_q, exp_i[idx], exp_q[idx]);
      end
    end
  endtask

  task automatic test_retune();
    logic [31:0] prev;
    logic [31:0] cur;
    logic [31:0] want;
    K = K_877;
    prev = dut.r_phase;
    for (int i = 1; i <= 1027; i++) begin
      step();
      cur  = dut.r_phase;
      want = (i <= 1024) ? K_QTR : K_877;
      total++;
      if (cur - prev !== want) begin
        bad++; $display("FAIL retune_diff: cyc %0d got %h want %h", i, cur - prev, want);
      end
      total++;
      if (tune_done !== (i == 1024)) begin
        bad++; $display("FAIL retune_tune: cyc %0d got %b want %b", i, tune_done, (i == 1024));
      end
      prev = cur;
    end
  endtask

  task automatic test_async_reset();
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (lo_i !== 12'sd0 || lo_q !== 12'sd0 || valid !== 1'b0 || tune_done !== 1'b0) begin
      bad++; $display("FAIL areset_out: got (%0d,%0d,v%b,t%b) want (0,0,v0,t0)", lo_i, lo_q, valid, tune_done);
    end
    total++;
    if (dut.r_phase !== 32'd0) begin bad++; $display("FAIL areset_phase: got %h want 0", dut.r_phase); end
    step();
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      total++;
      if (valid !== (i == 3)) begin bad++; $display("FAIL rerelease_valid: cyc %0d got %b want %b", i, valid, (i == 3)); end
    end
  endtask

  initial begin
    exp_i = '{12'sd2047, -12'sd2, -12'sd2047, 12'sd2};
    exp_q = '{12'sd2, 12'sd2047, -12'sd2, -12'sd2047};
    last_idx = 0;
    test_reset();
    test_glitch();
    test_quarter();
    test_en_hold();
    test_retune();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
